// File: rtl/seven_seg_scan_ctrl_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seven_seg_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  // Segment order g..a, active-high.
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  typedef enum logic [1:0] {
    OFF   = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

  typedef logic [$clog2(NUM_DIGITS)-1:0] digit_idx_t;

endpackage

// File: rtl/seven_seg_scan_ctrl_decode.sv
// BCD nibble to seven-segment pattern; non-decimal codes render as a blank digit.
module bcd_seg_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with blank interval per slot.
// Optional leading-zero suppression: define SEVEN_SEG_LZ_BLANK_EN.
module seven_seg_scan_ctrl
  import seven_seg_pkg::*;
#(
  parameter int unsigned DIV          = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        load,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  output logic [6:0]  seg,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame_done
);

  localparam int unsigned   CW            = $clog2(DIV);
  localparam logic [CW-1:0] CNT_BLANK_END = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] CNT_SLOT_END  = CW'(DIV - 1);

  scan_state_t   r_state, w_state_nxt;
  digit_idx_t    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;

  logic [15:0] r_shadow_val, r_active_val;
  logic [3:0]  r_shadow_dp, r_active_dp;

  logic [6:0] r_seg, w_seg_nxt;
  logic       r_dp_n, w_dp_n_nxt;
  logic [3:0] r_an_n, w_an_n_nxt;
  logic       r_frame_done, w_frame_done_nxt;

  logic       w_frame_start;
  logic [3:0] w_digit;
  logic [6:0] w_dec;
  logic       w_lz;

  // The counter spans the whole slot: BLANK occupies the low counts, SHOW the rest.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_cnt_nxt   = r_cnt + CW'(1);
    if (!enable) begin
      w_state_nxt = OFF;
      w_idx_nxt   = '0;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        OFF: begin
          w_state_nxt = BLANK;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
        BLANK: begin
          if (r_cnt == CNT_BLANK_END) w_state_nxt = SHOW;
        end
        SHOW: begin
          if (r_cnt == CNT_SLOT_END) begin
            w_state_nxt = BLANK;
            w_idx_nxt   = r_idx + 1'b1;
            w_cnt_nxt   = '0;
          end
        end
        default: begin
          w_state_nxt = OFF;
          w_idx_nxt   = '0;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign w_frame_start = (w_state_nxt == BLANK) && (w_idx_nxt == '0) && (r_state != BLANK);

  assign w_digit = r_active_val[{w_idx_nxt, 2'b00} +: 4];

  bcd_seg_decode u_dec (
    .i_bcd (w_digit),
    .o_seg (w_dec)
  );

`ifdef SEVEN_SEG_LZ_BLANK_EN
  always_comb begin
    w_lz = 1'b0;
    case (w_idx_nxt)
      2'd3:    w_lz = (r_active_val[15:12] == 4'd0);
      2'd2:    w_lz = (r_active_val[15:8] == 8'd0);
      2'd1:    w_lz = (r_active_val[15:4] == 12'd0);
      default: w_lz = 1'b0;
    endcase
  end
`else
  assign w_lz = 1'b0;
`endif

  // Outputs are computed from the next state so they line up with the registered state.
  always_comb begin
    w_seg_nxt        = SEG_BLANK;
    w_dp_n_nxt       = 1'b1;
    w_an_n_nxt       = '1;
    w_frame_done_nxt = (w_state_nxt == SHOW) && (w_idx_nxt == 2'd3) &&
                       (w_cnt_nxt == CNT_SLOT_END);
    if (w_state_nxt == SHOW) begin
      w_seg_nxt  = w_lz ? SEG_BLANK : w_dec;
      w_dp_n_nxt = ~r_active_dp[w_idx_nxt];
      w_an_n_nxt = ~(4'b0001 << w_idx_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= BLANK;
      r_idx        <= '0;
      r_cnt        <= '0;
      r_shadow_val <= '0;
      r_shadow_dp  <= '0;
      r_active_val <= '0;
      r_active_dp  <= '0;
      r_seg        <= SEG_BLANK;
      r_dp_n       <= 1'b1;
      r_an_n       <= '1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_idx        <= w_idx_nxt;
      r_cnt        <= w_cnt_nxt;
      r_seg        <= w_seg_nxt;
      r_dp_n       <= w_dp_n_nxt;
      r_an_n       <= w_an_n_nxt;
      r_frame_done <= w_frame_done_nxt;
      if (load) begin
        r_shadow_val <= value_in;
        r_shadow_dp  <= dp_in;
      end
      // Non-blocking copy takes the pre-load shadow when load coincides with frame start.
      if (w_frame_start) begin
        r_active_val <= r_shadow_val;
        r_active_dp  <= r_shadow_dp;
      end
    end
  end

  assign seg        = r_seg;
  assign dp_n       = r_dp_n;
  assign an_n       = r_an_n;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl (DIV=8, BLANK_CYCLES=2) against a frame-time reference model.
module tb_seven_seg_scan_ctrl;

  localparam int unsigned TB_DIV   = 8;
  localparam int unsigned TB_BLANK = 2;
  localparam int unsigned FRAME    = 4 * TB_DIV;

  localparam logic [6:0] SEG_TBL [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00
  };

  logic        clk = 1'b0;
  logic        reset_n, enable, load;
  logic [15:0] value_in;
  logic [3:0]  dp_in;
  logic [6:0]  seg;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame_done;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  seven_seg_scan_ctrl #(
    .DIV          (TB_DIV),
    .BLANK_CYCLES (TB_BLANK)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .load       (load),
    .value_in   (value_in),
    .dp_in      (dp_in),
    .seg        (seg),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: time since frame anchor plus the value captured for the current frame.
  int unsigned m_t;
  logic        m_off, m_valid = 1'b0;
  logic [15:0] m_shadow, m_frame;
  logic [3:0]  m_sdp, m_fdp;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_valid  <= 1'b1;
      m_t      <= 0;
      m_off    <= 1'b0;
      m_shadow <= '0;
      m_sdp    <= '0;
      m_frame  <= '0;
      m_fdp    <= '0;
    end else begin
      if (load) begin
        m_shadow <= value_in;
        m_sdp    <= dp_in;
      end
      if (!enable) begin
        m_off <= 1'b1;
      end else if (m_off) begin
        m_off   <= 1'b0;
        m_t     <= 0;
        m_frame <= m_shadow;
        m_fdp   <= m_sdp;
      end else begin
        m_t <= m_t + 1;
        if ((m_t + 1) % FRAME == 0) begin
          m_frame <= m_shadow;
          m_fdp   <= m_sdp;
        end
      end
    end
  end

  function automatic logic [6:0] exp_seg_f(input int unsigned slot, input logic [15:0] val);
    logic [3:0] nib;
    nib = 4'((val >> (4 * slot)) & 16'hF);
`ifdef SEVEN_SEG_LZ_BLANK_EN
    if (slot > 0 && (val >> (4 * slot)) == 16'd0) return 7'h00;
`endif
    return SEG_TBL[nib];
  endfunction

  int   last_lit = -1;
  int   off_run  = 0;

  always @(negedge clk) begin
    logic [6:0]  e_seg;
    logic        e_dp_n, e_fd;
    logic [3:0]  e_an;
    int unsigned ph, slot;
    if (m_valid) begin
      e_seg = 7'h00; e_dp_n = 1'b1; e_an = 4'hF; e_fd = 1'b0;
      if (!m_off) begin
        ph   = m_t % TB_DIV;
        slot = (m_t / TB_DIV) % 4;
        e_fd = (m_t % FRAME) == FRAME - 1;
        if (ph >= TB_BLANK) begin
          e_an   = ~(4'b0001 << slot);
          e_seg  = exp_seg_f(slot, m_frame);
          e_dp_n = ~m_fdp[slot];
        end
      end
      check("an_n", {28'd0, an_n}, {28'd0, e_an});
      check("seg", {25'd0, seg}, {25'd0, e_seg});
      check("dp_n", {31'd0, dp_n}, {31'd0, e_dp_n});
      check("frame_done", {31'd0, frame_done}, {31'd0, e_fd});
      check("an_onehot", {31'd0, ($countones(~an_n) <= 1)}, 32'd1);
      if (an_n == 4'hF) begin
        off_run <= off_run + 1;
      end else begin
        if (last_lit >= 0 && an_n != 4'(last_lit))
          check("blank_gap", {31'd0, (off_run >= int'(TB_BLANK))}, 32'd1);
        last_lit <= int'(an_n);
        off_run  <= 0;
      end
    end
  end

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [15:0] v, input logic [3:0] d);
    @(negedge clk);
    load = 1'b1; value_in = v; dp_in = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_an(input logic [3:0] pat, input string tag);
    int unsigned k = 0;
    while (an_n !== pat && k < 2 * FRAME) begin
      @(negedge clk);
      k++;
    end
    check(tag, {28'd0, an_n}, {28'd0, pat});
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; load = 1'b0; value_in = '0; dp_in = '0;
    cycles(3);
    reset_n = 1'b1;
    cycles(3);
    do_load(16'h1234, 4'b0000);
    cycles(3 * FRAME);

    wait_an(4'b1101, "wait_d1_show");
    load = 1'b1; value_in = 16'h0000; dp_in = 4'b0010;
    @(negedge clk);
    load = 1'b1; value_in = 16'h5678; dp_in = 4'b0101;
    @(negedge clk);
    load = 1'b0;
    cycles(2 * FRAME + 5);

    do_load(16'h00A7, 4'b0100);
    cycles(2 * FRAME + 3);

    wait_an(4'b1011, "wait_d2_show");
    enable = 1'b0;
    cycles(4);
    enable = 1'b1;
    cycles(FRAME + 7);

    do_load(16'h9999, 4'b1111);
    cycles(FRAME + 13);
    reset_n = 1'b0;
    cycles(1);
    reset_n = 1'b1;
    cycles(2 * FRAME);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      load     = ($urandom_range(0, 15) == 0);
      value_in = 16'($urandom);
      dp_in    = 4'($urandom);
      enable   = ($urandom_range(0, 63) != 0);
      reset_n  = ($urandom_range(0, 499) != 0);
    end
    @(negedge clk);
    load = 1'b0; enable = 1'b1; reset_n = 1'b1;
    cycles(2 * FRAME);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seven_seg_scan_ctrl.md
# seven_seg_scan_ctrl

Time-multiplexed scan controller for a four-digit common-anode seven-segment display. Holds a 16-bit packed BCD value, cycles through the four digits with a programmable dwell and an anti-ghosting blank interval, and drives shared segment lines plus per-digit anode enables. Sits between the arithmetic/counter logic that produces BCD results and the board display pins, and owns the only instance of the BCD-to-segment decoder.

## Interface
- DIV, default 50000: clock cycles per digit slot (blank plus show); legal range BLANK_CYCLES+1 to 2^20.
- BLANK_CYCLES, default 16: cycles at the start of each slot with all anodes off; must be at least 1 and less than DIV.
- clk  input  1  sole clock; all logic is on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- enable  input  1  scanning enabled when high.
- load  input  1  single-cycle strobe that captures value_in and dp_in.
- value_in  input  16  packed BCD; [3:0] is digit 0 (rightmost), [15:12] is digit 3.
- dp_in  input  4  decimal point request per digit, active-high.
- seg  output  7  segments g..a, active-high; bit 6 is g, bit 0 is a.
- dp_n  output  1  decimal point, active-low.
- an_n  output  4  digit anodes, active-low; bit i selects digit i.
- frame_done  output  1  one-cycle pulse at the end of digit 3's show phase.

## Operation
- Registers: shadow_val/shadow_dp are written on load. active_val/active_dp are copied from shadow at every frame start, so a frame never shows mixed old and new digits.
- A frame start is entry into BLANK for digit 0, whether by wrap-around, on leaving reset, or on re-enable.
- FSM states:
  - OFF: taken while enable is low.
  - BLANK: anodes off. Lasts BLANK_CYCLES cycles, then goes to SHOW.
  - SHOW: the selected anode is low; seg and dp_n carry the decoded active digit. Lasts DIV-BLANK_CYCLES cycles, then goes to BLANK of digit (idx+1) mod 4.
- OFF clears the slot counter, sets idx to 0, drives an_n=4'b1111, seg=0 and dp_n=1. When enable goes high, the FSM goes to BLANK of digit 0, which is a frame start.
- enable low has priority in any state and aborts the slot immediately.
- Decoding: 0–9 use the standard patterns (0 gives 7'b0111111, 1 gives 7'b0000110, 8 gives 7'b1111111, and so on). A nibble of 10–15 decodes to seg=0, a blank digit; it is not X.
- load together with a frame start in the same cycle: the copy takes the pre-load shadow contents, and the new value appears at the next frame.
- Slot counter width is clog2(DIV). It wraps to 0 on each slot change.

## Timing
- All outputs are registered. Reset values: seg=0, dp_n=1, an_n=4'b1111, frame_done=0, state BLANK, idx=0, counter=0, shadow and active registers zero.
- The first reset-released cycle counts as BLANK cycle 1 of digit 0.
- With reset_n high and enable high throughout, an_n of digit 0 goes low exactly BLANK_CYCLES cycles after release and stays low for DIV-BLANK_CYCLES cycles.
- Frame period is 4·DIV cycles.
- frame_done is high in the cycle where the registered outputs move from digit 3 SHOW to digit 0 BLANK.
- Load-to-display latency runs from the load cycle to the next frame start plus BLANK_CYCLES: at most 4·DIV+BLANK_CYCLES cycles.
- Reset asserted mid-slot takes effect at the next edge: outputs go to their reset values, and shadow is cleared, so any pending load is lost.
- At most one anode is low in any cycle. Between two consecutive lit digits there are at least BLANK_CYCLES cycles with all anodes high.

## Configuration
- Macro SEVEN_SEG_LZ_BLANK_EN.
- When defined: leading-zero suppression. Digit i (i = 3, 2, 1) is forced blank (seg=0) when it and every more-significant digit equal 0. Digit 0 is never suppressed. The decimal point is still driven from active_dp, so "  0.5" is displayable.
- When undefined: every digit is decoded as-is, so 0042 shows "0042".

## Structure
- Shared package seven_seg_pkg holds:
  - segment pattern constants SEG_0 to SEG_9 and SEG_BLANK;
  - the FSM state typedef (OFF, BLANK, SHOW);
  - the digit count constant NUM_DIGITS=4.
- One sub-module, bcd_seg_decode: combinational, 4-bit nibble to 7-bit segments, with blank output for 10–15. It is instantiated once on the muxed active digit.

## Test plan
All cases use DIV=8 and BLANK_CYCLES=2.
- Reset, then load 16'h1234 with enable high: frame 1 shows 0000. Frame 2 shows digit 0 with seg 7'b1100110, digit 1 with 7'b1001111, digit 2 with 7'b1011011, and digit 3 with 7'b0000110. Each anode is low for 6 cycles after 2 blank cycles, and frame_done pulses every 32 cycles.
- Load 16'h0000, then 16'h5678, during digit-1 SHOW: no frame shows a mix of the two values, and the new value appears at the next frame start.
- Value 16'h00A7 with the macro undefined: digit 1 (A) gives seg=0, digit 0 gives 7'b0000111, and digits 3 and 2 give 7'b0111111. With the macro defined, digits 3, 2 and 1 give seg=0.
- Drop enable during digit-2 SHOW: the next cycle shows an_n=1111 and seg=0. Re-enable: digit 0 lights after 2 cycles.
- Assert reset_n=0 for one cycle mid-frame after loading 16'h9999: all outputs return to reset values, and the subsequent display shows 0000.
- Assertion over a full run: one-hot-or-none on an_n, and at least 2 all-off cycles between consecutive lit anodes.
